// File: rtl/multicycle_main_control_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, ALUOp codes
// (also consumed by the ALU control decoder), FSM states and mux select encodings.
package multicycle_main_control_pkg;

   localparam int ALUOP_W  = 4;
   localparam int OPCODE_W = 6;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
   localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD = 4'b0000;
   localparam logic [ALUOP_W-1:0] ALUOP_SW  = 4'b0001;
   localparam logic [ALUOP_W-1:0] ALUOP_BEQ = 4'b0010;
   localparam logic [ALUOP_W-1:0] ALUOP_BNE = 4'b0011;
   localparam logic [ALUOP_W-1:0] ALUOP_R   = 4'b0100;
   localparam logic [ALUOP_W-1:0] ALUOP_SET = 4'b0101;
   localparam logic [ALUOP_W-1:0] ALUOP_JMP = 4'b0110;

   // 13 and 14 are named only so the full 4-bit space is covered by the enum.
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MADDR   = 4'd2,
      S_MREAD   = 4'd3,
      S_MWB     = 4'd4,
      S_MWRITE  = 4'd5,
      S_REXE    = 4'd6,
      S_RWB     = 4'd7,
      S_BEQ     = 4'd8,
      S_BNE     = 4'd9,
      S_JMP     = 4'd10,
      S_SETEXE  = 4'd11,
      S_IWB     = 4'd12,
      S_RSVD13  = 4'd13,
      S_RSVD14  = 4'd14,
      S_ILLEGAL = 4'd15
   } state_e;

   typedef enum logic [1:0] {
      SRCB_B      = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } srcb_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_RSVD   = 2'b11
   } pcsrc_e;

   typedef struct packed {
      logic                pc_write;
      logic                pc_write_cond;
      logic                pc_write_cond_ne;
      logic                i_or_d;
      logic                mem_read;
      logic                mem_write;
      logic                ir_write;
      logic                mem_to_reg;
      logic                reg_dst;
      logic                reg_write;
      logic                alu_src_a;
      srcb_e               alu_src_b;
      pcsrc_e              pc_source;
      logic [ALUOP_W-1:0]  alu_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_main_control_if
   import multicycle_main_control_pkg::*;
#(
   parameter int ICNT_W = 32
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                pc_write_cond_ne;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                mem_to_reg;
   logic                reg_dst;
   logic                reg_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          pc_source;
   logic [ALUOP_W-1:0]  alu_op;
   logic [3:0]          state;
   logic                illegal;
   logic [ICNT_W-1:0]   instr_count;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
             pc_source, alu_op, state, illegal, instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
             pc_source, alu_op, state, illegal, instr_count
   );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences each instruction
// and drives the datapath enables; memory states hold while mem_ready is low.
module multicycle_main_control
   import multicycle_main_control_pkg::*;
#(
   parameter int ICNT_W = 32
)(
   input  logic                        clk,
   input  logic                        rst_n,
   multicycle_main_control_if.master   bus
);

   state_e              state_q, state_d;
   logic                illegal_q;
   logic [ICNT_W-1:0]   icnt_q;
   ctrl_t               ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         icnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_ILLEGAL)
            illegal_q <= 1'b1;
         // Retire on return to fetch; S_ILLEGAL never returns, so it is never counted.
         if (state_d == S_FETCH && state_q != S_FETCH)
            icnt_q <= icnt_q + ICNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MADDR;
               OP_RTYPE:     state_d = S_REXE;
               OP_BEQ:       state_d = S_BEQ;
               OP_BNE:       state_d = S_BNE;
               OP_J:         state_d = S_JMP;
               OP_SLTI:      state_d = S_SETEXE;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MADDR:   state_d = (bus.opcode == OP_SW) ? S_MWRITE : S_MREAD;
         S_MREAD:   if (bus.mem_ready) state_d = S_MWB;
         S_MWB:     state_d = S_FETCH;
         S_MWRITE:  if (bus.mem_ready) state_d = S_FETCH;
         S_REXE:    state_d = S_RWB;
         S_RWB:     state_d = S_FETCH;
         S_BEQ:     state_d = S_FETCH;
         S_BNE:     state_d = S_FETCH;
         S_JMP:     state_d = S_FETCH;
         S_SETEXE:  state_d = S_IWB;
         S_IWB:     state_d = S_FETCH;
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_ILLEGAL;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.ir_write  = bus.mem_ready;
            ctrl.pc_write  = bus.mem_ready;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
         S_MADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = (bus.opcode == OP_SW) ? ALUOP_SW : ALUOP_ADD;
         end
         S_MREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MWRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_REXE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_R;
         end
         S_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_BEQ;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_BNE: begin
            ctrl.alu_src_a        = 1'b1;
            ctrl.alu_op           = ALUOP_BNE;
            ctrl.pc_write_cond_ne = 1'b1;
            ctrl.pc_source        = PCSRC_ALUOUT;
         end
         S_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.alu_op    = ALUOP_JMP;
         end
         S_SETEXE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_SET;
         end
         S_IWB: ctrl.reg_write = 1'b1;
         default: ctrl = '0;
      endcase
      // The reset state is S_FETCH, whose strobes must not leak while reset is held.
      if (!rst_n) ctrl = '0;
   end

   assign bus.pc_write         = ctrl.pc_write;
   assign bus.pc_write_cond    = ctrl.pc_write_cond;
   assign bus.pc_write_cond_ne = ctrl.pc_write_cond_ne;
   assign bus.i_or_d           = ctrl.i_or_d;
   assign bus.mem_read         = ctrl.mem_read;
   assign bus.mem_write        = ctrl.mem_write;
   assign bus.ir_write         = ctrl.ir_write;
   assign bus.mem_to_reg       = ctrl.mem_to_reg;
   assign bus.reg_dst          = ctrl.reg_dst;
   assign bus.reg_write        = ctrl.reg_write;
   assign bus.alu_src_a        = ctrl.alu_src_a;
   assign bus.alu_src_b        = ctrl.alu_src_b;
   assign bus.pc_source        = ctrl.pc_source;
   assign bus.alu_op           = ctrl.alu_op;
   assign bus.state            = state_q;
   assign bus.illegal          = illegal_q;
   assign bus.instr_count      = icnt_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: directed steps plus randomized
// instruction streams compared against a per-instruction phase/output table.
module tb_multicycle_main_control;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] model_cnt = '0;

   multicycle_main_control_if #(.ICNT_W(32)) bus ();

   multicycle_main_control #(.ICNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                          T_BEQ = 6'b000100, T_BNE = 6'b000101, T_J = 6'b000010,
                          T_SLTI = 6'b001010, T_BAD = 6'b111111;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] obs_vec();
      return {bus.pc_write, bus.pc_write_cond, bus.pc_write_cond_ne, bus.i_or_d,
              bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
              bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.alu_op,
              bus.illegal};
   endfunction

   // Expected strobes for a given cycle of an instruction, straight from the state table.
   function automatic logic [19:0] exp_vec(input int st, input logic [5:0] op, input logic rdy);
      logic pcw, pwc, pwcne, iord, mr, mw, irw, m2r, rdst, rw, srca, ill;
      logic [1:0] srcb, psrc;
      logic [3:0] aop;
      {pcw, pwc, pwcne, iord, mr, mw, irw, m2r, rdst, rw, srca, ill} = '0;
      srcb = 2'd0; psrc = 2'd0; aop = 4'd0;
      case (st)
         0:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
         1:  srcb = 2'b11;
         2:  begin srca = 1; srcb = 2'b10; aop = (op == T_SW) ? 4'b0001 : 4'b0000; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iord = 1; end
         6:  begin srca = 1; aop = 4'b0100; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin srca = 1; aop = 4'b0010; pwc = 1; psrc = 2'b01; end
         9:  begin srca = 1; aop = 4'b0011; pwcne = 1; psrc = 2'b01; end
         10: begin pcw = 1; psrc = 2'b10; aop = 4'b0110; end
         11: begin srca = 1; srcb = 2'b10; aop = 4'b0101; end
         12: rw = 1;
         15: ill = 1;
         default: ;
      endcase
      return {pcw, pwc, pwcne, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, psrc, aop, ill};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int st, input logic [5:0] op, input logic rdy, input string tag);
      bus.opcode    = op;
      bus.mem_ready = rdy;
      #1;
      chk({tag, ".state"}, 64'(bus.state), 64'(st));
      chk({tag, ".outs"}, 64'(obs_vec()), 64'(exp_vec(st, op, rdy)));
   endtask

   // Runs one legal instruction; fst/mst are stall cycles in fetch and in the memory state.
   task automatic run_instr(input logic [5:0] op, input int fst, input int mst, input string tag);
      int ph[5];
      int n;
      int stalls;
      case (op)
         T_LW:    begin ph = '{0, 1, 2, 3, 4};  n = 5; end
         T_SW:    begin ph = '{0, 1, 2, 5, 0};  n = 4; end
         T_R:     begin ph = '{0, 1, 6, 7, 0};  n = 4; end
         T_SLTI:  begin ph = '{0, 1, 11, 12, 0}; n = 4; end
         T_BEQ:   begin ph = '{0, 1, 8, 0, 0};  n = 3; end
         T_BNE:   begin ph = '{0, 1, 9, 0, 0};  n = 3; end
         default: begin ph = '{0, 1, 10, 0, 0}; n = 3; end
      endcase
      chk({tag, ".count"}, 64'(bus.instr_count), 64'(model_cnt));
      for (int i = 0; i < n; i++) begin
         stalls = (ph[i] == 0) ? fst : ((ph[i] == 3 || ph[i] == 5) ? mst : 0);
         for (int k = 0; k <= stalls; k++) begin
            if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5)
               step(ph[i], op, (k == stalls), tag);
            else
               step(ph[i], op, 1'($urandom_range(0, 1)), tag);
            tick();
         end
      end
      model_cnt = model_cnt + 32'd1;
   endtask

   initial begin
      logic [5:0] legal [7];
      logic [5:0] op;
      legal = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_SLTI};
      bus.opcode    = T_R;
      bus.mem_ready = 1'b1;
      #2;
      chk("reset.state", 64'(bus.state), 64'd0);
      chk("reset.outs", 64'(obs_vec()), 64'd0);
      chk("reset.count", 64'(bus.instr_count), 64'd0);
      tick();
      rst_n = 1'b1;

      run_instr(T_LW, 0, 0, "lw");
      run_instr(T_SW, 0, 2, "sw_stall");
      run_instr(T_R, 0, 0, "rtype");
      run_instr(T_BEQ, 0, 0, "beq");
      run_instr(T_BNE, 0, 0, "bne");
      run_instr(T_SLTI, 1, 0, "slti");
      run_instr(T_J, 0, 0, "jmp");
      run_instr(T_LW, 2, 1, "lw_stall");
      chk("count.directed", 64'(bus.instr_count), 64'd8);

      for (int i = 0; i < 40; i++) begin
         op = legal[$urandom_range(0, 6)];
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), "rand");
      end
      chk("count.rand", 64'(bus.instr_count), 64'(model_cnt));

      // Abort a stalled load with reset.
      step(0, T_LW, 1'b1, "abort"); tick();
      step(1, T_LW, 1'b1, "abort"); tick();
      step(2, T_LW, 1'b1, "abort"); tick();
      step(3, T_LW, 1'b0, "abort"); tick();
      step(3, T_LW, 1'b0, "abort");
      rst_n = 1'b0;
      model_cnt = '0;
      #1;
      chk("abort.state", 64'(bus.state), 64'd0);
      chk("abort.outs", 64'(obs_vec()), 64'd0);
      chk("abort.count", 64'(bus.instr_count), 64'd0);
      tick();
      chk("abort.held", 64'(obs_vec()), 64'd0);
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      chk("release.ir_write", 64'(bus.ir_write), 64'd1);
      run_instr(T_R, 0, 0, "post_reset");
      chk("post_reset.count", 64'(bus.instr_count), 64'd1);

      // Illegal opcode: terminal, inert, never counted.
      step(0, T_BAD, 1'b1, "ill"); tick();
      step(1, T_BAD, 1'b1, "ill"); tick();
      for (int i = 0; i < 10; i++) begin
         step(15, T_BAD, 1'($urandom_range(0, 1)), "ill_hold");
         chk("ill_hold.count", 64'(bus.instr_count), 64'(model_cnt));
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("ill_reset.illegal", 64'(bus.illegal), 64'd0);
      chk("ill_reset.state", 64'(bus.state), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
Main control FSM of the multi-cycle MIPS-subset CPU. Decodes the 6-bit opcode, sequences each instruction through fetch/decode/execute/memory/writeback cycles, and drives all datapath enables. It is the producer of the 4-bit ALUOp consumed by the ALU control decoder. Memory accesses use a ready handshake, so the FSM holds a state while memory stalls.

Parameters:
ALUOP_W, 4, width of alu_op bus (fixed encoding below)
OPCODE_W, 6, instruction opcode width
ICNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from S_DECODE onward
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_write_cond_ne  out  1  PC load if not ALU zero (bne)
i_or_d  out  1  0=PC addresses memory, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  1=MDR to regfile
reg_dst  out  1  1=rd, 0=rt
reg_write  out  1  regfile write enable
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_op  out  4  ALUOp to ALU control
state  out  4  current state (debug)
illegal  out  1  sticky illegal-opcode flag
instr_count  out  ICNT_W  retired instructions

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, slti 001010; all others illegal.
- ALUOp: lw/add 0000, sw 0001, beq 0010, bne 0011, R 0100, set 0101, jmp 0110.
- Moore outputs: each output is a function of state only, except the mem_ready-qualified strobes listed below. Every output not listed for a state is 0 and alu_op is 0000.
- State encoding:
  - S_FETCH=0: mem_read=1, alu_src_b=01, alu_op=0000. ir_write=pc_write=mem_ready. Stay while !mem_ready; else go to S_DECODE.
  - S_DECODE=1: alu_src_b=11, alu_op=0000. Branches on opcode: lw/sw to S_MADDR, R to S_REXE, beq to S_BEQ, bne to S_BNE, j to S_JMP, slti to S_SETEXE, else S_ILLEGAL.
  - S_MADDR=2: alu_src_a=1, alu_src_b=10, alu_op=0000 (lw) or 0001 (sw). Next is S_MREAD for lw, S_MWRITE for sw.
  - S_MREAD=3: mem_read=1, i_or_d=1. Hold until mem_ready, then go to S_MWB.
  - S_MWB=4: reg_write=1, mem_to_reg=1, reg_dst=0. Next is S_FETCH.
  - S_MWRITE=5: mem_write=1, i_or_d=1. Hold until mem_ready, then go to S_FETCH.
  - S_REXE=6: alu_src_a=1, alu_src_b=00, alu_op=0100. Next is S_RWB.
  - S_RWB=7: reg_write=1, reg_dst=1. Next is S_FETCH.
  - S_BEQ=8: alu_src_a=1, alu_op=0010, pc_write_cond=1, pc_source=01. Next is S_FETCH.
  - S_BNE=9: as S_BEQ but alu_op=0011 and pc_write_cond_ne=1.
  - S_JMP=10: pc_write=1, pc_source=10, alu_op=0110. Next is S_FETCH.
  - S_SETEXE=11: alu_src_a=1, alu_src_b=10, alu_op=0101. Next is S_IWB.
  - S_IWB=12: reg_write=1, reg_dst=0. Next is S_FETCH.
  - S_ILLEGAL=15: all strobes 0, illegal=1. Terminal until reset.
  - Encodings 13 and 14 are unreachable. If ever entered, the next state is S_ILLEGAL.
- mem_read and mem_write stay asserted and stable throughout a stall.
- instr_count increments by 1 on each transition into S_FETCH from any other state, wrapping modulo 2^ICNT_W. It does not count S_ILLEGAL.
- Cycle counts with no stalls: lw 5, sw 4, R 4, slti 4, beq/bne/j 3. Each cycle of mem_ready=0 in S_FETCH, S_MREAD or S_MWRITE adds one cycle.
- Reset: asynchronous when rst_n=0. state=S_FETCH, illegal=0, instr_count=0. While rst_n is low, all strobes are forced to 0 and alu_op=0000. Reset mid-instruction aborts it with no further writes. After release, the first edge evaluates S_FETCH normally.

Decomposition:
- Shared package holds the opcode constants, ALUOp constants (shared with the ALU control decoder), state encodings, and the alu_src_b/pc_source select encodings.
- Single module; no sub-module needed. The next-state logic and the output decode are separate always blocks.

Test Plan:
- Reset asserted mid-S_MREAD → outputs 0 immediately, state=0, instr_count=0. After release with mem_ready=1, fetch ir_write=1 on the first cycle.
- lw (100011), mem_ready=1 → states 0,1,2,3,4,0. alu_op in S_MADDR is 0000; S_MWB has reg_write=1 and mem_to_reg=1; instr_count=1.
- sw with mem_ready low for 2 cycles in S_MWRITE → mem_write=1 for 3 consecutive cycles, then S_FETCH. Total 6 cycles.
- R-type (000000) → S_REXE alu_op=0100, alu_src_b=00; S_RWB reg_write=1, reg_dst=1; 4 cycles.
- beq then bne → S_BEQ pc_write_cond=1, alu_op=0010, pc_source=01; S_BNE pc_write_cond_ne=1, alu_op=0011. instr_count=2.
- opcode 111111 → S_ILLEGAL, illegal=1. It persists for 10 cycles with no reg_write/mem_write/pc_write, and instr_count stays unchanged.
